// File: rtl/layered_objects_mux.sv
// Two-stage priority compositor: lowest-index enabled, requesting, non-keyed object wins over background.
// Also tracks per-frame object collisions, reported as a snapshot at each frame_start.
module layered_objects_mux #(
  parameter int                   NUM_OBJECTS     = 8,
  parameter int                   RGB_WIDTH       = 8,
  parameter logic [RGB_WIDTH-1:0] TRANSPARENT_RGB = {RGB_WIDTH{1'b1}},
  parameter int                   COLL_CNT_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pixel_valid,
  input  logic                               frame_start,
  input  logic [NUM_OBJECTS-1:0]             draw_requests,
  input  logic [NUM_OBJECTS*RGB_WIDTH-1:0]   obj_RGB,
  input  logic [RGB_WIDTH-1:0]               background_RGB,
  input  logic                               mask_we,
  input  logic [NUM_OBJECTS-1:0]             mask_wdata,
  output logic [RGB_WIDTH-1:0]               RGBOut,
  output logic                               RGBOut_valid,
  output logic [$clog2(NUM_OBJECTS)-1:0]     winner_index,
  output logic                               winner_is_obj,
  output logic [NUM_OBJECTS-1:0]             collision_flags,
  output logic [COLL_CNT_WIDTH-1:0]          collision_count,
  output logic                               collision_valid
);

  localparam int IDX_W = $clog2(NUM_OBJECTS);
  localparam int PC_W  = IDX_W + 1;

  logic [NUM_OBJECTS-1:0]    mask_q;
  logic [NUM_OBJECTS-1:0]    eff;
  logic [PC_W-1:0]           pop_cnt;
  logic [IDX_W-1:0]          sel_idx;
  logic [RGB_WIDTH-1:0]      sel_rgb;
  logic                      sel_any;
  logic                      coll_hit;

  logic                      s1_valid_q;
  logic [IDX_W-1:0]          s1_idx_q;
  logic                      s1_obj_q;
  logic [RGB_WIDTH-1:0]      s1_rgb_q;

  logic                      out_valid_q;
  logic [IDX_W-1:0]          out_idx_q;
  logic                      out_obj_q;
  logic [RGB_WIDTH-1:0]      out_rgb_q;

  logic [NUM_OBJECTS-1:0]    sticky_flags_q;
  logic [COLL_CNT_WIDTH-1:0] sticky_cnt_q;
  logic [NUM_OBJECTS-1:0]    coll_flags_q;
  logic [COLL_CNT_WIDTH-1:0] coll_cnt_q;
  logic                      coll_valid_q;

  always_comb begin
    eff     = '0;
    pop_cnt = '0;
    sel_idx = '0;
    sel_rgb = background_RGB;
    for (int i = 0; i < NUM_OBJECTS; i++) begin
      eff[i]  = draw_requests[i] & mask_q[i] &
                (obj_RGB[i*RGB_WIDTH +: RGB_WIDTH] != TRANSPARENT_RGB);
      pop_cnt = pop_cnt + PC_W'(eff[i]);
    end
    // Scan from the top so the lowest index overwrites last and wins.
    for (int i = NUM_OBJECTS - 1; i >= 0; i--) begin
      if (eff[i]) begin
        sel_idx = IDX_W'(i);
        sel_rgb = obj_RGB[i*RGB_WIDTH +: RGB_WIDTH];
      end
    end
    sel_any  = |eff;
    coll_hit = pixel_valid && (pop_cnt >= PC_W'(2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q         <= '1;
      s1_valid_q     <= 1'b0;
      s1_idx_q       <= '0;
      s1_obj_q       <= 1'b0;
      s1_rgb_q       <= '0;
      out_valid_q    <= 1'b0;
      out_idx_q      <= '0;
      out_obj_q      <= 1'b0;
      out_rgb_q      <= '0;
      sticky_flags_q <= '0;
      sticky_cnt_q   <= '0;
      coll_flags_q   <= '0;
      coll_cnt_q     <= '0;
      coll_valid_q   <= 1'b0;
    end else begin
      if (mask_we) mask_q <= mask_wdata;

      s1_valid_q <= pixel_valid;
      if (pixel_valid) begin
        s1_idx_q <= sel_idx;
        s1_obj_q <= sel_any;
        s1_rgb_q <= sel_rgb;
      end

      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_idx_q <= s1_idx_q;
        out_obj_q <= s1_obj_q;
        out_rgb_q <= s1_rgb_q;
      end

      // A collision on the frame_start cycle seeds the new frame.
      coll_valid_q <= frame_start;
      if (frame_start) begin
        coll_flags_q   <= sticky_flags_q;
        coll_cnt_q     <= sticky_cnt_q;
        sticky_flags_q <= coll_hit ? eff : '0;
        sticky_cnt_q   <= coll_hit ? COLL_CNT_WIDTH'(1) : '0;
      end else if (coll_hit) begin
        sticky_flags_q <= sticky_flags_q | eff;
        if (sticky_cnt_q != '1) sticky_cnt_q <= sticky_cnt_q + COLL_CNT_WIDTH'(1);
      end
    end
  end

  assign RGBOut          = out_rgb_q;
  assign RGBOut_valid    = out_valid_q;
  assign winner_index    = out_idx_q;
  assign winner_is_obj   = out_obj_q;
  assign collision_flags = coll_flags_q;
  assign collision_count = coll_cnt_q;
  assign collision_valid = coll_valid_q;

endmodule
